// File: rtl/bbpd_vote_filter_if.sv
// Sample-word input and Up/Dn decision output bundle of the
// bang-bang phase detector.
interface bbpd_vote_filter_if #(
   parameter int WIDTH = 10,
   parameter int VW    = 7
);
   logic                    valid_in;
   logic [WIDTH-1:0]        data_in;
   logic [WIDTH-1:0]        edge_in;
   logic                    Up;
   logic                    Dn;
   logic signed [VW-1:0]    vote_out;
   logic                    locked;

   modport master (
      output valid_in, data_in, edge_in,
      input  Up, Dn, vote_out, locked
   );

   modport slave (
      input  valid_in, data_in, edge_in,
      output Up, Dn, vote_out, locked
   );
endinterface

// File: rtl/bbpd_vote_filter.sv
// Alexander phase detector: per-word early/late popcount, windowed
// majority vote with Up/Dn pulses and a drift-based lock flag.
module bbpd_vote_filter #(
   parameter int WIDTH    = 10,
   parameter int DECIM    = 4,
   parameter int THRESH   = 2,
   parameter int LOCK_WIN = 64,
   parameter int LOCK_TOL = 4
) (
   input logic              clk,
   input logic              rst_n,
   bbpd_vote_filter_if.slave bus
);
   localparam int VW  = $clog2(WIDTH*DECIM+1)+1;
   localparam int CW  = $clog2(WIDTH+1);
   localparam int WCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int LCW = (LOCK_WIN > 1) ? $clog2(LOCK_WIN) : 1;
   localparam int DW  = $clog2(LOCK_WIN+1)+1;
   localparam logic signed [VW-1:0] THR = VW'(THRESH);
   localparam logic signed [DW-1:0] TOL = DW'(LOCK_TOL);

   logic              prev_bit;
   logic              first;
   logic [WIDTH:0]    dext;
   logic [CW-1:0]     late_c;
   logic [CW-1:0]     early_c;
   logic [CW-1:0]     s1_late;
   logic [CW-1:0]     s1_early;
   logic              s1_valid;

   // dext[i] is the sample preceding data bit i
   always_comb begin
      dext    = {bus.data_in, prev_bit};
      late_c  = '0;
      early_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if ((dext[i] != dext[i+1]) && !(i == 0 && first)) begin
            if (bus.edge_in[i] == dext[i+1])
               late_c = late_c + CW'(1);
            else
               early_c = early_c + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_bit <= 1'b0;
         first    <= 1'b1;
         s1_late  <= '0;
         s1_early <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= bus.valid_in;
         if (bus.valid_in) begin
            s1_late  <= late_c;
            s1_early <= early_c;
            prev_bit <= bus.data_in[WIDTH-1];
            first    <= 1'b0;
         end
      end
   end

   logic signed [VW-1:0] net;
   logic signed [VW-1:0] net_nx;
   logic [WCW-1:0]       wcnt;
   logic                 last_word;
   logic                 d_up;
   logic                 d_dn;
   logic signed [DW-1:0] drift;
   logic signed [DW-1:0] drift_nx;
   logic [LCW-1:0]       lcnt;
   logic                 lock_end;
   logic                 lock_ok;

   always_comb begin
      net_nx = net
             + $signed({{(VW-CW){1'b0}}, s1_late})
             - $signed({{(VW-CW){1'b0}}, s1_early});
      last_word = (wcnt == WCW'(DECIM-1));
      d_up      = (net_nx >= THR);
      d_dn      = !d_up && (net_nx <= -THR);
      drift_nx  = drift;
      if (d_up)
         drift_nx = drift + DW'(1);
      else if (d_dn)
         drift_nx = drift - DW'(1);
      lock_end = (lcnt == LCW'(LOCK_WIN-1));
      lock_ok  = (drift_nx <= TOL) && (drift_nx >= -TOL);
   end

   logic                 up_q;
   logic                 dn_q;
   logic signed [VW-1:0] vote_q;
   logic                 locked_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         net      <= '0;
         wcnt     <= '0;
         drift    <= '0;
         lcnt     <= '0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         vote_q   <= '0;
         locked_q <= 1'b0;
      end else begin
         up_q <= 1'b0;
         dn_q <= 1'b0;
         if (s1_valid) begin
            if (last_word) begin
               net    <= '0;
               wcnt   <= '0;
               vote_q <= net_nx;
               up_q   <= d_up;
               dn_q   <= d_dn;
               if (lock_end) begin
                  locked_q <= lock_ok;
                  drift    <= '0;
                  lcnt     <= '0;
               end else begin
                  drift <= drift_nx;
                  lcnt  <= lcnt + LCW'(1);
               end
            end else begin
               net  <= net_nx;
               wcnt <= wcnt + WCW'(1);
            end
         end
      end
   end

   assign bus.Up       = up_q;
   assign bus.Dn       = dn_q;
   assign bus.vote_out = vote_q;
   assign bus.locked   = locked_q;
endmodule

// File: tb/tb_bbpd_vote_filter.sv
// Randomized and directed bench for bbpd_vote_filter against a
// word-level behavioural model of the vote/lock rules.
module tb_bbpd_vote_filter;
   localparam int WIDTH    = 10;
   localparam int DECIM    = 4;
   localparam int THRESH   = 2;
   localparam int LOCK_WIN = 64;
   localparam int LOCK_TOL = 4;
   localparam int VW       = $clog2(WIDTH*DECIM+1)+1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bbpd_vote_filter_if #(.WIDTH(WIDTH), .VW(VW)) bus ();

   bbpd_vote_filter #(
      .WIDTH(WIDTH), .DECIM(DECIM), .THRESH(THRESH),
      .LOCK_WIN(LOCK_WIN), .LOCK_TOL(LOCK_TOL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Net vote of one word: +1 per late transition, -1 per early one
   function automatic int word_score(input logic [WIDTH-1:0] d,
                                     input logic [WIDTH-1:0] e,
                                     input bit pb, input bit fst);
      int s;
      bit dp;
      s = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == 0) dp = pb;
         else        dp = d[i-1];
         if (!(i == 0 && fst) && (dp != d[i]))
            s += (e[i] == d[i]) ? 1 : -1;
      end
      return s;
   endfunction

   // Model state
   bit m_prev, m_first;
   int m_cnt, m_net, m_dec, m_drift;
   bit p_dec, p_up, p_dn, p_lk, p_lkval;
   int p_vote;
   int e_up, e_dn, e_vote, e_locked;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev = 0; m_first = 1;
         m_cnt = 0; m_net = 0; m_dec = 0; m_drift = 0;
         p_dec = 0; p_up = 0; p_dn = 0; p_lk = 0; p_lkval = 0; p_vote = 0;
         e_up = 0; e_dn = 0; e_vote = 0; e_locked = 0;
      end else begin
         e_up = p_up;
         e_dn = p_dn;
         if (p_dec) e_vote = p_vote;
         if (p_lk)  e_locked = p_lkval;
         p_dec = 0; p_up = 0; p_dn = 0; p_lk = 0;
         if (bus.valid_in === 1'b1) begin
            m_net += word_score(bus.data_in, bus.edge_in, m_prev, m_first);
            m_prev  = bus.data_in[WIDTH-1];
            m_first = 0;
            m_cnt++;
            if (m_cnt == DECIM) begin
               p_dec  = 1;
               p_vote = m_net;
               p_up   = (m_net >= THRESH);
               p_dn   = (m_net <= -THRESH);
               m_drift += int'(p_up) - int'(p_dn);
               m_dec++;
               if (m_dec == LOCK_WIN) begin
                  p_lk    = 1;
                  p_lkval = (m_drift <= LOCK_TOL) && (m_drift >= -LOCK_TOL);
                  m_drift = 0;
                  m_dec   = 0;
               end
               m_net = 0;
               m_cnt = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("up", int'(bus.Up), e_up);
      chk("dn", int'(bus.Dn), e_dn);
      chk("vote", int'(bus.vote_out), e_vote);
      chk("locked", int'(bus.locked), e_locked);
      chk("up_dn_excl", int'(bus.Up & bus.Dn), 0);
   end

   localparam logic [WIDTH-1:0] PAT = 10'b1010101010;

   task automatic send(input bit v, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] e);
      bus.valid_in = v;
      bus.data_in  = d;
      bus.edge_in  = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) begin
         bus.valid_in = 1'($urandom);
         bus.data_in  = WIDTH'($urandom);
         bus.edge_in  = WIDTH'($urandom);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      int bias;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] e;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.edge_in  = '0;
      do_reset();
      chk("rst_up", int'(bus.Up), 0);
      chk("rst_vote", int'(bus.vote_out), 0);
      chk("rst_locked", int'(bus.locked), 0);

      // Late stream
      repeat (4) send(1, PAT, PAT);
      chk("late_w1_up", int'(bus.Up), 0);
      send(1, PAT, PAT);
      chk("late_w1_up", int'(bus.Up), 1);
      chk("late_w1_vote", int'(bus.vote_out), 39);
      repeat (3) send(1, PAT, PAT);
      send(0, PAT, PAT);
      chk("late_w2_up", int'(bus.Up), 1);
      chk("late_w2_vote", int'(bus.vote_out), 40);

      // Early stream
      do_reset();
      repeat (5) send(1, PAT, ~PAT);
      chk("early_w1_dn", int'(bus.Dn), 1);
      chk("early_w1_vote", int'(bus.vote_out), -39);
      repeat (3) send(1, PAT, ~PAT);
      send(0, PAT, PAT);
      chk("early_w2_dn", int'(bus.Dn), 1);
      chk("early_w2_vote", int'(bus.vote_out), -40);

      // Threshold
      do_reset();
      send(1, 10'b0000000001, 10'b0000000001);
      repeat (3) send(1, '0, '0);
      send(1, 10'b0000000110, 10'b0000000110);
      chk("thr1_vote", int'(bus.vote_out), 1);
      chk("thr1_up", int'(bus.Up), 0);
      chk("thr1_dn", int'(bus.Dn), 0);
      repeat (3) send(1, '0, '0);
      send(0, '0, '0);
      chk("thr2_vote", int'(bus.vote_out), 2);
      chk("thr2_up", int'(bus.Up), 1);

      // Gaps in valid_in
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         send(1, PAT, PAT);
         send(0, ~PAT, 10'h3ff);
         if (k == 4) begin
            chk("gap_w1_up", int'(bus.Up), 1);
            chk("gap_w1_vote", int'(bus.vote_out), 39);
         end
         if (k == 8) begin
            chk("gap_w2_up", int'(bus.Up), 1);
            chk("gap_w2_vote", int'(bus.vote_out), 40);
         end
         send(0, '0, '0);
      end

      // Lock acquire and loss
      do_reset();
      for (int w = 0; w < LOCK_WIN; w++)
         repeat (DECIM) send(1, PAT, (w % 2 == 0) ? PAT : ~PAT);
      send(0, '0, '0);
      chk("lock_acq", int'(bus.locked), 1);
      for (int w = 0; w < LOCK_WIN; w++) begin
         repeat (DECIM) send(1, PAT, PAT);
         if (w == LOCK_WIN-1)
            chk("lock_hold", int'(bus.locked), 1);
      end
      send(0, '0, '0);
      chk("lock_lost", int'(bus.locked), 0);

      // Randomized traffic with occasional mid-window resets
      bias = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) bias = int'($urandom_range(0, 3));
         d = WIDTH'($urandom);
         case (bias)
            0:       e = d;
            1:       e = ~d;
            2:       e = d ^ WIDTH'(($urandom_range(0, 3) == 0) ? $urandom : 0);
            default: e = WIDTH'($urandom);
         endcase
         if ($urandom_range(0, 599) == 0)
            do_reset();
         else
            send($urandom_range(0, 3) != 0, d, e);
      end
      send(0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
